// File: rtl/chn_pkg.sv
// Shared definitions for the two-channel block merger / demultiplexer pair:
// channel-select encoding, header magic, defaults and the demux state type.
package chn_pkg;

    localparam logic CHN1 = 1'b0;
    localparam logic CHN2 = 1'b1;

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BLOCK_LEN = 1023;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HDR  = 2'd1,
        ST_HUNT = 2'd2
    } state_e;

    // Header word that precedes every block of channel chn in the header build.
    function automatic logic [15:0] hdr_word(input logic chn);
        return {HDR_MAGIC, 7'h00, chn};
    endfunction

endpackage

// File: rtl/chn_block_demux.sv
// chn_block_demux: splits the merged word stream (alternating BLOCK_LEN-word
// blocks, channel 1 first) back into two channel strobes with block status.
// Build option CHN_BLOCK_DEMUX_HDR_EN: each block is preceded by a header
// word {A5, 7'h00, chn}; adds HDR/HUNT states and the sticky sync_err flag.
module chn_block_demux
    import chn_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int CNT_W     = 10,
    parameter int BLKCNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                resync,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_en,
    output logic [DATA_W-1:0]   chn1_dout,
    output logic                chn1_dout_en,
    output logic [DATA_W-1:0]   chn2_dout,
    output logic                chn2_dout_en,
    output logic                blk_done,
    output logic                blk_chn,
    output logic [BLKCNT_W-1:0] blk_cnt,
    output logic                sync_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

`ifdef CHN_BLOCK_DEMUX_HDR_EN
    localparam state_e ST_RESET  = ST_HUNT;
    localparam state_e ST_RESYNC = ST_HDR;
`else
    localparam state_e ST_RESET  = ST_RUN;
    localparam state_e ST_RESYNC = ST_RUN;
`endif

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic [DATA_W-1:0]     c1_q, c1_d;
    logic                  c1en_q, c1en_d;
    logic [DATA_W-1:0]     c2_q, c2_d;
    logic                  c2en_q, c2en_d;
    logic                  done_q, done_d;
    logic                  bchn_q, bchn_d;
    logic [BLKCNT_W-1:0]   bcnt_q, bcnt_d;
`ifdef CHN_BLOCK_DEMUX_HDR_EN
    logic                  serr_q, serr_d;
`endif

    // Next-state logic: routing, block accounting and header tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        c1_d    = c1_q;
        c1en_d  = 1'b0;
        c2_d    = c2_q;
        c2en_d  = 1'b0;
        done_d  = 1'b0;
        bchn_d  = bchn_q;
        bcnt_d  = bcnt_q;
`ifdef CHN_BLOCK_DEMUX_HDR_EN
        serr_d  = serr_q;
`endif
        if (resync) begin
            // Word presented together with resync is intentionally dropped.
            cnt_d   = '0;
            sel_d   = CHN1;
            state_d = ST_RESYNC;
        end else if (din_en) begin
            unique case (state_q)
                ST_RUN: begin
                    if (sel_q == CHN1) begin
                        c1_d   = din;
                        c1en_d = 1'b1;
                    end else begin
                        c2_d   = din;
                        c2en_d = 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        cnt_d  = '0;
                        sel_d  = (sel_q == CHN1) ? CHN2 : CHN1;
                        done_d = 1'b1;
                        bchn_d = sel_q;
                        bcnt_d = bcnt_q + BLKCNT_W'(1);
`ifdef CHN_BLOCK_DEMUX_HDR_EN
                        state_d = ST_HDR;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef CHN_BLOCK_DEMUX_HDR_EN
                ST_HDR: begin
                    if (din == DATA_W'(hdr_word(sel_q))) begin
                        state_d = ST_RUN;
                    end else begin
                        serr_d  = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    // Realign only on a channel-1 header: blocks restart in pairs.
                    if (din == DATA_W'(hdr_word(CHN1))) begin
                        sel_d   = CHN1;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
`endif
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State and output registers; reset clears everything including data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            sel_q   <= CHN1;
            c1_q    <= '0;
            c1en_q  <= 1'b0;
            c2_q    <= '0;
            c2en_q  <= 1'b0;
            done_q  <= 1'b0;
            bchn_q  <= 1'b0;
            bcnt_q  <= '0;
`ifdef CHN_BLOCK_DEMUX_HDR_EN
            serr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            c1_q    <= c1_d;
            c1en_q  <= c1en_d;
            c2_q    <= c2_d;
            c2en_q  <= c2en_d;
            done_q  <= done_d;
            bchn_q  <= bchn_d;
            bcnt_q  <= bcnt_d;
`ifdef CHN_BLOCK_DEMUX_HDR_EN
            serr_q  <= serr_d;
`endif
        end
    end

    assign chn1_dout    = c1_q;
    assign chn1_dout_en = c1en_q;
    assign chn2_dout    = c2_q;
    assign chn2_dout_en = c2en_q;
    assign blk_done     = done_q;
    assign blk_chn      = bchn_q;
    assign blk_cnt      = bcnt_q;
`ifdef CHN_BLOCK_DEMUX_HDR_EN
    assign sync_err     = serr_q;
`else
    assign sync_err     = 1'b0;
`endif

endmodule

// File: tb/tb_chn_block_demux.sv
// Self-checking bench for chn_block_demux (default build and, when
// CHN_BLOCK_DEMUX_HDR_EN is defined, the header build). A behavioural model
// derives each word's channel from its position in the stream.
module tb_chn_block_demux;

    localparam int DW  = 16;
    localparam int BL  = 1023;
    localparam int BCW = 4;

    localparam int M_RUN  = 0;
    localparam int M_HDR  = 1;
    localparam int M_HUNT = 2;

    logic           clk = 1'b0;
    logic           rst, resync, din_en;
    logic [DW-1:0]  din;
    logic [DW-1:0]  chn1_dout, chn2_dout;
    logic           chn1_dout_en, chn2_dout_en, blk_done, blk_chn, sync_err;
    logic [BCW-1:0] blk_cnt;

    chn_block_demux #(
        .DATA_W(DW), .BLOCK_LEN(BL), .CNT_W(10), .BLKCNT_W(BCW)
    ) dut (
        .clk(clk), .rst(rst), .resync(resync), .din(din), .din_en(din_en),
        .chn1_dout(chn1_dout), .chn1_dout_en(chn1_dout_en),
        .chn2_dout(chn2_dout), .chn2_dout_en(chn2_dout_en),
        .blk_done(blk_done), .blk_chn(blk_chn), .blk_cnt(blk_cnt),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int            m_pos;
    int            m_mode;
    int            m_bcnt;
    logic          m_serr;
    logic [DW-1:0] e_c1, e_c2;
    logic          e_c1en, e_c2en, e_done, e_bchn;

    int obs_c1, obs_c2, obs_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int reset_mode();
`ifdef CHN_BLOCK_DEMUX_HDR_EN
        return M_HUNT;
`else
        return M_RUN;
`endif
    endfunction

    function automatic int resync_mode();
`ifdef CHN_BLOCK_DEMUX_HDR_EN
        return M_HDR;
`else
        return M_RUN;
`endif
    endfunction

    // Apply the current inputs to the model to get next-cycle expectations.
    task automatic model_step();
        logic ch;
        e_c1en = 1'b0;
        e_c2en = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_pos = 0; m_mode = reset_mode(); m_bcnt = 0; m_serr = 1'b0;
            e_c1 = '0; e_c2 = '0; e_bchn = 1'b0;
        end else if (resync) begin
            m_pos = 0; m_mode = resync_mode();
        end else if (din_en) begin
            ch = ((m_pos / BL) % 2) != 0;
            case (m_mode)
                M_RUN: begin
                    if (!ch) begin e_c1 = din; e_c1en = 1'b1; end
                    else     begin e_c2 = din; e_c2en = 1'b1; end
                    m_pos++;
                    if (m_pos % BL == 0) begin
                        e_done = 1'b1;
                        e_bchn = ch;
                        m_bcnt = (m_bcnt + 1) % (1 << BCW);
                        if (resync_mode() == M_HDR) m_mode = M_HDR;
                    end
                end
                M_HDR: begin
                    if (din == {8'hA5, 7'h00, ch}) m_mode = M_RUN;
                    else begin m_serr = 1'b1; m_mode = M_HUNT; end
                end
                default: begin
                    if (din == 16'hA500) begin m_pos = 0; m_mode = M_RUN; end
                end
            endcase
        end
    endtask

    // One clock: model step, edge, then compare every output.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("chn1_dout",    chn1_dout,    e_c1);
        check("chn1_dout_en", chn1_dout_en, e_c1en);
        check("chn2_dout",    chn2_dout,    e_c2);
        check("chn2_dout_en", chn2_dout_en, e_c2en);
        check("blk_done",     blk_done,     e_done);
        check("blk_cnt",      blk_cnt,      m_bcnt);
        check("sync_err",     sync_err,     m_serr);
        if (e_done) check("blk_chn", blk_chn, e_bchn);
        if (chn1_dout_en) obs_c1++;
        if (chn2_dout_en) obs_c2++;
        if (blk_done)     obs_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din_en = 1'b0;
            din    = DW'($urandom);
            cycle();
        end
    endtask

    task automatic put(input logic [DW-1:0] w, input bit gaps);
        if (gaps) idle($urandom_range(2, 0));
        din    = w;
        din_en = 1'b1;
        cycle();
        din_en = 1'b0;
    endtask

    // Send count payload words start..; pos0 is the stream position of the first.
    task automatic stream(input int start, input int count, input int pos0, input bit gaps);
        for (int i = 0; i < count; i++) begin
`ifdef CHN_BLOCK_DEMUX_HDR_EN
            if ((pos0 + i) % BL == 0)
                put({8'hA5, 7'h00, 1'(((pos0 + i) / BL) % 2)}, gaps);
`endif
            put(DW'(start + i), gaps);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; resync = 1'b0; din_en = 1'b0; din = '0;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_blk_chn", blk_chn, 1'b0);
        obs_c1 = 0; obs_c2 = 0; obs_done = 0;
    endtask

    initial begin
        rst = 1'b1; resync = 1'b0; din_en = 1'b0; din = '0;
        obs_c1 = 0; obs_c2 = 0; obs_done = 0;
        m_pos = 0; m_mode = reset_mode(); m_bcnt = 0; m_serr = 1'b0;
        e_c1 = '0; e_c2 = '0; e_c1en = 1'b0; e_c2en = 1'b0; e_done = 1'b0; e_bchn = 1'b0;

        // contiguous two-block stream
        do_reset();
        stream(0, 2 * BL, 0, 1'b0);
        idle(2);
        check("t1_c1_cnt", obs_c1, BL);
        check("t1_c2_cnt", obs_c2, BL);
        check("t1_done",   obs_done, 2);
        check("t1_blkcnt", blk_cnt, 2);

        // same stream with random gaps
        do_reset();
        stream(0, 2 * BL, 0, 1'b1);
        idle(3);
        check("t2_c1_cnt", obs_c1, BL);
        check("t2_c2_cnt", obs_c2, BL);
        check("t2_done",   obs_done, 2);
        check("t2_blkcnt", blk_cnt, 2);

        // resync after 500 chn1 words; dropped word coincides with resync
        do_reset();
        stream(0, 500, 0, 1'b0);
        resync = 1'b1; din_en = 1'b1; din = 16'hDEAD;
        cycle();
        resync = 1'b0; din_en = 1'b0;
        stream(5000, BL, 0, 1'b1);
        idle(2);
        check("t3_c1_cnt", obs_c1, 500 + BL);
        check("t3_c2_cnt", obs_c2, 0);
        check("t3_done",   obs_done, 1);
        check("t3_blkcnt", blk_cnt, 1);

        // block counter wrap with a 4-bit counter
        do_reset();
        stream(0, 17 * BL, 0, 1'b0);
        idle(2);
        check("t4_done",   obs_done, 17);
        check("t4_blkcnt", blk_cnt, 1);

        // rst together with resync mid-block
        stream(0, 300, 0, 1'b0);
        rst = 1'b1; resync = 1'b1; din_en = 1'b1; din = 16'hBEEF;
        cycle();
        check("t5_c1_zero", chn1_dout, 0);
        check("t5_c2_zero", chn2_dout, 0);
        check("t5_bcnt_zero", blk_cnt, 0);
        check("t5_bchn_zero", blk_chn, 0);
        rst = 1'b0; resync = 1'b0; din_en = 1'b0;
        obs_c1 = 0; obs_c2 = 0; obs_done = 0;
        stream(100, BL, 0, 1'b0);
        idle(2);
        check("t5_c1_cnt", obs_c1, BL);
        check("t5_c2_cnt", obs_c2, 0);
        check("t5_done",   obs_done, 1);

`ifdef CHN_BLOCK_DEMUX_HDR_EN
        // header mismatch, hunt, realign on chn1 header
        do_reset();
        resync = 1'b1; cycle(); resync = 1'b0;
        put(16'hA501, 1'b0);
        check("t6_serr_set", sync_err, 1'b1);
        for (int i = 0; i < 5; i++) put(16'h1234 + 16'(i), 1'b1);
        check("t6_hunt_drop", obs_c1 + obs_c2, 0);
        put(16'hA500, 1'b0);
        for (int i = 0; i < BL; i++) put(16'(7000 + i), 1'b0);
        idle(2);
        check("t6_c1_cnt", obs_c1, BL);
        check("t6_serr_sticky", sync_err, 1'b1);
        resync = 1'b1; cycle(); resync = 1'b0;
        check("t6_serr_resync", sync_err, 1'b1);
        do_reset();
        check("t6_serr_rst", sync_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chn_block_demux.md
Name: chn_block_demux

Overview:
- Receive-side counterpart of the two-channel block merger: consumes the merged 16-bit word stream and routes each word back to its originating channel.
- Stream format: alternating blocks of BLOCK_LEN words, channel 1 first.
- Sits after the USB external-FIFO read path (loopback/verification data path). Drives per-channel word strobes plus block status.

Parameters:
- DATA_W, 16, word width.
- BLOCK_LEN, 1023, words per block (payload, excluding header).
- CNT_W, 10, block word-counter width; must satisfy 2^CNT_W > BLOCK_LEN.
- BLKCNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- resync  in  1  synchronous restart: next accepted word is word 0 of a channel-1 block.
- din  in  DATA_W  merged stream word.
- din_en  in  1  din valid this cycle; no backpressure.
- chn1_dout  out  DATA_W  channel-1 word.
- chn1_dout_en  out  1  chn1_dout valid, one-cycle strobe.
- chn2_dout  out  DATA_W  channel-2 word.
- chn2_dout_en  out  1  chn2_dout valid, one-cycle strobe.
- blk_done  out  1  one-cycle pulse when the last word of a block is routed.
- blk_chn  out  1  channel of the block just completed (0 = chn1, 1 = chn2); valid with blk_done.
- blk_cnt  out  BLKCNT_W  completed-block count; wraps modulo 2^BLKCNT_W.
- sync_err  out  1  sticky header-mismatch flag (header build only; tied 0 otherwise).

Behaviour:
- Reset: all outputs 0, word counter 0, channel select = chn1, state RUN (HUNT in header build).
- Latency: din/din_en registered to chnX_dout/chnX_dout_en in exactly 1 cycle.
- The output of the unselected channel holds its last value; its _en stays 0.
- States: RUN (routing payload), plus HDR and HUNT in the header build.
- RUN, din_en=1:
  - Route din to the selected channel.
  - If cnt == BLOCK_LEN-1: cnt <= 0, toggle select, blk_done=1, blk_chn=old select, blk_cnt++ (all in the same registered cycle as the last word's strobe).
  - Otherwise cnt++.
- din_en=0: no state change. Gaps of any length inside a block are legal.
- resync=1: cnt <= 0, select <= chn1, state <= HDR (header build) or RUN. Any word presented in the same cycle is dropped. blk_cnt and sync_err are not cleared; only rst clears them.
- rst has priority over resync. Reset mid-block discards the partial block with no blk_done.
- blk_cnt wrap: all-ones + 1 -> 0, with no flag.

Optional Feature:
- Macro CHN_BLOCK_DEMUX_HDR_EN.
- Defined: each block is preceded by one header word {8'hA5, 7'h00, chn}.
  - HDR state: the next valid word is compared with the expected header.
    - Match: enter RUN; header not forwarded.
    - Mismatch: set sync_err (sticky), enter HUNT.
  - HUNT: discard words until a valid word equals {8'hA5, 7'h00, 1'b0}; then set select=chn1, cnt=0, enter RUN.
  - After the last payload word, RUN -> HDR.
  - Reset state is HUNT.
- Undefined: no header words, no HDR/HUNT states, sync_err constant 0.

Decomposition:
- Shared package chn_pkg:
  - Channel-select encoding CHN1=1'b0, CHN2=1'b1.
  - HDR_MAGIC = 8'hA5.
  - Default BLOCK_LEN = 1023; common DATA_W = 16.
  - State encoding typedef.
- No sub-module required. Optional helper chn_hdr_check (combinational header compare) only if reused by the merger's header generator.

Test Plan:
- rst, then 2*1023 contiguous words 0..2045 -> chn1 gets 0..1022, chn2 gets 1023..2045, each 1 cycle later; blk_done pulses twice, blk_chn 0 then 1; blk_cnt=2.
- Same stream with din_en toggling 1-0-1 randomly -> identical routed sequences; no extra or missing strobes.
- resync asserted after 500 chn1 words, then 1023 new words -> all 1023 on chn1; blk_done once with blk_chn=0.
- blk_cnt preset near wrap (BLKCNT_W=4, 17 blocks) -> blk_cnt reads 1 after the 17th blk_done.
- HDR_EN: feed header 16'hA501 when 16'hA500 is expected -> sync_err=1, words discarded until 16'hA500, then normal chn1 routing; sync_err stays 1 until rst.
- rst asserted mid-block together with resync -> all outputs 0 next cycle; the next 1023 words go to chn1.
